// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter and its round-robin picker.
// Requesters hold re or we with addr/din until their one-cycle ready pulse; re wins over we.
package mem_arbiter_pkg;

  function automatic int ports_of(input int port_bits);
    return 1 << port_bits;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first pending port searching upward from last_grant+1 with wrap-around.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the selection.
module rr_select
  import mem_arbiter_pkg::*;
#(
  parameter int PORT_BITS = 1,
  localparam int PORTS = ports_of(PORT_BITS)
) (
  input  logic [PORTS-1:0]     pending,
  input  logic [PORT_BITS-1:0] last_grant,
  output logic [PORT_BITS-1:0] grant,
  output logic                 any
);

  logic [PORT_BITS-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending port overwrites the rest;
  // offset PORTS truncates to last_grant itself, giving it the lowest priority.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = PORTS; i >= 1; i--) begin
      idx = last_grant + PORT_BITS'(i);
      if (pending[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one re/we/ready memory port among PORTS requesters.
// Latency: grant to strobe 1 cycle, ready pulse 1 cycle after downstream mready returns.
// Backpressure: no grant while mready is low; one transaction outstanding at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int PORT_BITS  = 1,
  localparam int PORTS = ports_of(PORT_BITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [PORTS*WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0]       dout,
  input  logic [PORTS-1:0]            re,
  input  logic [PORTS-1:0]            we,
  output logic [PORTS-1:0]            ready,
  output logic [ADDR_WIDTH-1:0]       maddr,
  output logic [WORD_WIDTH-1:0]       mout,
  input  logic [WORD_WIDTH-1:0]       min,
  output logic                        mre,
  output logic                        mwe,
  input  logic                        mready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [PORT_BITS-1:0] grant;
  logic [PORT_BITS-1:0] last_grant;
  logic [PORT_BITS-1:0] sel;
  logic                 sel_any;
  logic                 op_read;
  logic [PORTS-1:0]     pending;

  assign pending = re | we;

  rr_select #(
    .PORT_BITS(PORT_BITS)
  ) u_rr_select (
    .pending   (pending),
    .last_grant(last_grant),
    .grant     (sel),
    .any       (sel_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= '1;
      op_read    <= 1'b0;
      maddr      <= '0;
      mout       <= '0;
      dout       <= '0;
      mre        <= 1'b0;
      mwe        <= 1'b0;
      ready      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any && mready) begin
            grant   <= sel;
            maddr   <= addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
            mout    <= din[sel*WORD_WIDTH +: WORD_WIDTH];
            op_read <= re[sel];
            mre     <= re[sel];
            mwe     <= !re[sel];
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          mre   <= 1'b0;
          mwe   <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (mready) begin
            if (op_read) dout <= min;
            ready[grant] <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          ready      <= '0;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with four ports and a behavioural downstream memory.
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int WW = 64;
  localparam int PB = 2;
  localparam int NP = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*AW-1:0] addr;
  logic [NP*WW-1:0] din;
  logic [WW-1:0]    dout;
  logic [NP-1:0]    re, we, ready;
  logic [AW-1:0]    maddr;
  logic [WW-1:0]    mout;
  logic [WW-1:0]    min;
  logic             mre, mwe, mready;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .WORD_WIDTH(WW),
    .PORT_BITS (PB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .re    (re),
    .we    (we),
    .ready (ready),
    .maddr (maddr),
    .mout  (mout),
    .min   (min),
    .mre   (mre),
    .mwe   (mwe),
    .mready(mready)
  );

  // d holds write data for writes and the expected read data for reads
  typedef struct {logic r; logic w; logic [AW-1:0] a; logic [WW-1:0] d;} req_t;
  typedef struct {logic rd; logic [WW-1:0] d; int cyc;} exp_t;

  req_t   pend_q[NP][$];
  exp_t   exp_q[NP][$];
  req_t   strobe_log[$];
  int     grant_log[$];
  logic   busy[NP];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     last_lat = 0;
  int     done_cnt = 0;
  logic [WW-1:0] last_dout;
  logic   in_txn, prev_strobe;
  logic [AW-1:0] txn_a;
  logic [WW-1:0] txn_d;

  // Downstream memory: mready drops after a sampled strobe and returns after dm_lat cycles.
  logic [WW-1:0] mem [logic [AW-1:0]];
  logic          dm_ready, dm_rd, force_busy;
  int            dm_lat, dm_cnt;
  logic [AW-1:0] dm_a;

  assign mready = dm_ready && !force_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      dm_ready <= 1'b1;
      dm_cnt   <= 0;
    end else if ((mre || mwe) && mready) begin
      dm_ready <= 1'b0;
      dm_cnt   <= dm_lat;
      dm_rd    <= mre;
      dm_a     <= maddr;
      if (!mre) mem[maddr] = mout;
    end else if (!dm_ready) begin
      if (dm_cnt <= 1) begin
        dm_ready <= 1'b1;
        if (dm_rd) min <= mem.exists(dm_a) ? mem[dm_a] : '0;
      end else begin
        dm_cnt <= dm_cnt - 1;
      end
    end
  end

  // Requester driver and scoreboard, both away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      re = '0; we = '0; addr = '0; din = '0;
      for (int p = 0; p < NP; p++) begin
        busy[p] = 1'b0;
        pend_q[p].delete();
        exp_q[p].delete();
      end
      in_txn = 1'b0; prev_strobe = 1'b0; last_dout = '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (!busy[p] && pend_q[p].size() > 0) begin
          req_t r;
          r = pend_q[p].pop_front();
          re[p] = r.r; we[p] = r.w;
          addr[p*AW +: AW] = r.a;
          din[p*WW +: WW]  = r.d;
          busy[p] = 1'b1;
          exp_q[p].push_back('{rd: r.r, d: r.d, cyc: cyc});
        end
      end
      if (mre || mwe) begin
        checks++;
        if (prev_strobe) begin
          errors++;
          $display("FAIL strobe_len: strobe high two cycles in a row, required one cycle");
        end
        strobe_log.push_back('{r: mre, w: mwe, a: maddr, d: mout});
        in_txn = 1'b1; txn_a = maddr; txn_d = mout;
      end else if (in_txn) begin
        checks++;
        if (maddr !== txn_a || mout !== txn_d) begin
          errors++;
          $display("FAIL hold: maddr=%h mout=%h, required %h %h", maddr, mout, txn_a, txn_d);
        end
      end
      prev_strobe = mre || mwe;
      if (ready != '0) begin
        checks++;
        if ($countones(ready) != 1) begin
          errors++;
          $display("FAIL onehot: ready=%b, required exactly one bit", ready);
        end
        for (int p = 0; p < NP; p++) begin
          if (ready[p]) begin
            checks++;
            if (exp_q[p].size() == 0) begin
              errors++;
              $display("FAIL unexpected_ready: port %0d pulsed, required no pulse", p);
            end else begin
              exp_t e;
              e = exp_q[p].pop_front();
              if (e.rd) begin
                if (dout !== e.d) begin
                  errors++;
                  $display("FAIL rdata port %0d: dout=%h, required %h", p, dout, e.d);
                end
                last_dout = e.d;
              end else if (dout !== last_dout) begin
                errors++;
                $display("FAIL wr_dout port %0d: dout=%h, required unchanged %h", p, dout, last_dout);
              end
              last_lat = cyc - e.cyc;
            end
            grant_log.push_back(p);
            re[p] = 1'b0; we[p] = 1'b0; busy[p] = 1'b0;
            done_cnt++;
            in_txn = 1'b0;
          end
        end
      end
    end
  end

  function automatic bit quiet();
    for (int p = 0; p < NP; p++)
      if (busy[p] || pend_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (quiet()) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; force_busy = 1'b0; dm_lat = 1; min = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mre !== 1'b0)   begin errors++; $display("FAIL reset_mre: %b, required 0", mre); end
    checks++; if (mwe !== 1'b0)   begin errors++; $display("FAIL reset_mwe: %b, required 0", mwe); end
    checks++; if (ready !== '0)   begin errors++; $display("FAIL reset_ready: %b, required 0", ready); end
    checks++; if (dout !== '0)    begin errors++; $display("FAIL reset_dout: %h, required 0", dout); end
    checks++; if (maddr !== '0)   begin errors++; $display("FAIL reset_maddr: %h, required 0", maddr); end
    checks++; if (mout !== '0)    begin errors++; $display("FAIL reset_mout: %h, required 0", mout); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    bit ok;
    int d0;
    mem[64'h40] = 64'hDEAD; dm_lat = 2;
    strobe_log.delete(); d0 = done_cnt;
    pend_q[0].push_back('{r: 1'b1, w: 1'b0, a: 64'h40, d: 64'hDEAD});
    wait_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_timeout: no ready within budget"); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL read_pulses: %0d, required 1", done_cnt - d0); end
    checks++;
    if (strobe_log.size() != 1 || strobe_log[0].r !== 1'b1 || strobe_log[0].w !== 1'b0 || strobe_log[0].a !== 64'h40) begin
      errors++;
      $display("FAIL read_strobe: %0d strobes, required one mre with maddr=40", strobe_log.size());
    end
    checks++; if (last_lat != 5) begin errors++; $display("FAIL read_latency: %0d cycles, required 5", last_lat); end
  endtask

  task automatic test_single_write();
    bit ok;
    dm_lat = 2; strobe_log.delete();
    pend_q[1].push_back('{r: 1'b0, w: 1'b1, a: 64'h80, d: 64'h1234});
    wait_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_timeout: no ready within budget"); end
    checks++;
    if (strobe_log.size() != 1 || strobe_log[0].w !== 1'b1 || strobe_log[0].r !== 1'b0 ||
        strobe_log[0].a !== 64'h80 || strobe_log[0].d !== 64'h1234) begin
      errors++;
      $display("FAIL write_strobe: %0d strobes, required one mwe maddr=80 mout=1234", strobe_log.size());
    end
    checks++;
    if (mem[64'h80] !== 64'h1234) begin errors++; $display("FAIL write_mem: %h, required 1234", mem[64'h80]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    dm_lat = 1; grant_log.delete();
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      a = 64'h100 + 64'(i * 8);
      mem[a] = 64'hA000 + 64'(i);
      pend_q[i % 2].push_back('{r: 1'b1, w: 1'b0, a: a, d: 64'hA000 + 64'(i)});
    end
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: requests left pending"); end
    checks++;
    if (grant_log.size() != 8) begin errors++; $display("FAIL b2b_count: %0d grants, required 8", grant_log.size()); end
    for (int i = 0; i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] != i % 2) begin
        errors++;
        $display("FAIL b2b_order[%0d]: port %0d, required %0d", i, grant_log[i], i % 2);
      end
    end
  endtask

  task automatic test_read_priority();
    bit ok;
    force_busy = 1'b1; dm_lat = 1; strobe_log.delete();
    mem[64'h200] = 64'hCAFE;
    pend_q[2].push_back('{r: 1'b1, w: 1'b1, a: 64'h200, d: 64'hCAFE});
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (strobe_log.size() != 0) begin errors++; $display("FAIL busy_strobe: %0d strobes while mready=0, required 0", strobe_log.size()); end
    force_busy = 1'b0;
    wait_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_timeout: no ready within budget"); end
    checks++;
    if (strobe_log.size() != 1 || strobe_log[0].r !== 1'b1 || strobe_log[0].w !== 1'b0) begin
      errors++;
      $display("FAIL prio_op: %0d strobes, required one read strobe with mwe=0", strobe_log.size());
    end
    checks++;
    if (mem[64'h200] !== 64'hCAFE) begin errors++; $display("FAIL prio_mem: %h, required CAFE untouched", mem[64'h200]); end
  endtask

  task automatic test_wrap();
    bit ok;
    dm_lat = 1; grant_log.delete();
    mem[64'h300] = 64'h3333; mem[64'h308] = 64'h0808;
    pend_q[0].push_back('{r: 1'b1, w: 1'b0, a: 64'h308, d: 64'h0808});
    pend_q[3].push_back('{r: 1'b1, w: 1'b0, a: 64'h300, d: 64'h3333});
    wait_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: requests left pending"); end
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 3 || grant_log[1] != 0) begin
      errors++;
      $display("FAIL wrap_order: %0d grants first=%0d, required 3 then 0", grant_log.size(),
               grant_log.size() > 0 ? grant_log[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    dm_lat = 6; strobe_log.delete();
    pend_q[1].push_back('{r: 1'b1, w: 1'b0, a: 64'h40, d: 64'hDEAD});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = strobe_log.size() > 0;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_strobe: no strobe within budget"); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mre !== 1'b0 || mwe !== 1'b0 || ready !== '0) begin
      errors++;
      $display("FAIL mid_reset: mre=%b mwe=%b ready=%b, required all 0", mre, mwe, ready);
    end
    checks++; if (dout !== '0) begin errors++; $display("FAIL mid_dout: %h, required 0", dout); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    dm_lat = 1; grant_log.delete();
    pend_q[1].push_back('{r: 1'b1, w: 1'b0, a: 64'h80, d: 64'h1234});
    pend_q[0].push_back('{r: 1'b1, w: 1'b0, a: 64'h40, d: 64'hDEAD});
    wait_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL post_timeout: requests left pending"); end
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      errors++;
      $display("FAIL post_order: %0d grants first=%0d, required 0 then 1", grant_log.size(),
               grant_log.size() > 0 ? grant_log[0] : -1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_read_priority();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one memory-hierarchy port among 2^PORT_BITS requesters.
- Typically several cores or DMA engines front a single cache; a cache level may also be shared toward main memory.
- Upstream and downstream both use the re/we/ready word protocol of the cache block.
- Latches one request at a time and holds address, data and operation stable on the downstream port for the whole transaction.
- Returns read data with a one-cycle ready pulse to the granted port.

Parameters:
- ADDR_WIDTH, 64: address width in bits.
- WORD_WIDTH, 64: data word width in bits.
- PORT_BITS, 1: 2^n requester ports (PORTS = 1 << PORT_BITS).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- addr  in  PORTS*ADDR_WIDTH  packed request addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- din  in  PORTS*WORD_WIDTH  packed write data, same packing.
- dout  out  WORD_WIDTH  registered read data, shared by all ports.
- re  in  PORTS  read request per port, level.
- we  in  PORTS  write request per port, level.
- ready  out  PORTS  one-cycle completion pulse per port.
- maddr  out  ADDR_WIDTH  downstream address.
- mout  out  WORD_WIDTH  downstream write data.
- min  in  WORD_WIDTH  downstream read data.
- mre  out  1  downstream read strobe.
- mwe  out  1  downstream write strobe.
- mready  in  1  downstream idle/done.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, mre=mwe=0, ready=0, dout=0, maddr=mout=0.
  - last_grant=PORTS-1, so port 0 wins first.
  - Reset mid-transaction abandons it without a ready pulse; the downstream block shares rst.
- Upstream contract:
  - A port raises re or we with addr/din and holds them until its ready pulse.
  - It drops them in the cycle after the pulse.
  - re and we both high on one port means read; we is ignored.
  - If a port drops its request early, the transaction still completes and the pulse is still issued.
- Downstream contract: mready drops in the cycle after mre/mwe is sampled, and rises again when the transaction completes; min is valid while mready is high after a read.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: pending = re|we.
    - If pending!=0 and mready=1, grant the first pending port searching from last_grant+1 mod PORTS (wrap-around).
    - Latch grant index, addr slice into maddr, din slice into mout, and op (read if re[g]); go ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE: mre=op_read, mwe=!op_read, exactly one cycle; go WAIT.
  - WAIT: strobes low. When mready=1, dout<=min (read only; a write leaves dout unchanged) and go DONE.
  - DONE: ready[grant]=1 for this cycle only; last_grant<=grant; go IDLE.
- maddr/mout are held from latch until the next grant; they never change during ISSUE/WAIT/DONE.
- Minimum latency against the cache on a hit:
  - request seen in IDLE at cycle 0;
  - strobe in cycle 1;
  - mready high in cycle 3;
  - ready pulse in cycle 4.
- At most one transaction is outstanding; no request is granted while mready=0.
- A requester that holds its request across DONE is not re-granted twice, because IDLE follows DONE and the requester has dropped by then.
- mre, mwe and ready are registered or decoded from the state register only; no combinational path from inputs to outputs.

Decomposition:
- Shared include file: the re/we/ready protocol notes and the PORT_BITS/PORTS derivation.
- State encodings stay as localparams inside mem_arbiter.
- One natural sub-module, rr_select:
  - combinational round-robin picker;
  - inputs: pending[PORTS], last_grant[PORT_BITS];
  - outputs: grant[PORT_BITS], any.
  - Reused by later schedulers.

Test Plan:
- Single read, port 0, addr=0x40, downstream returns 0xDEAD after 2 busy cycles -> mre high exactly one cycle with maddr=0x40; ready[0] pulses once; dout=0xDEAD in that cycle.
- Single write, port 1, addr=0x80, din=0x1234 -> mwe one cycle, maddr=0x80, mout=0x1234 stable until ready[1]; dout unchanged.
- Ports 0 and 1 request every cycle (PORT_BITS=1) -> grants alternate 0,1,0,1 over 8 transactions; never two ready bits high at once.
- PORT_BITS=2, only ports 3 and 0 pending with last_grant=2 -> port 3 first, then port 0 (wrap-around).
- re and we both high on port 2 -> read issued (mre=1, mwe=0); request while mready=0 -> no strobe until mready=1.
- rst low during WAIT -> next cycle state IDLE, all ready=0, mre=mwe=0; port 0 granted first after release.
